// File: rtl/riscv_test_sequencer.sv
// On-board compliance runner: sequences NUM_TESTS images through load, CPU reset,
// run and halt/timeout detection, and keeps a pass/fail scoreboard for debug logic.
module riscv_test_sequencer #(
  parameter int unsigned NUM_TESTS    = 38,
  parameter int unsigned IDX_W        = 6,
  parameter int unsigned CYC_W        = 32,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] HALT_INSTR   = 32'hdead10cc,
  parameter logic [31:0] PASS_MAGIC   = 32'h00c0ffee,
  parameter logic [31:0] FAIL_MAGIC   = 32'hdeaddead
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             load_req,
  input  logic             load_done,
  input  logic             retire_valid,
  input  logic [31:0]      retire_instr,
  input  logic [31:0]      a0_value,
  output logic             cpu_rst_n,
  output logic [IDX_W-1:0] test_idx,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic             result_valid,
  output logic [1:0]       result_code,
  output logic [CYC_W-1:0] last_cycles,
  output logic [IDX_W:0]   pass_count,
  output logic [IDX_W:0]   err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RST, S_RUN, S_CHECK, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   test_idx_q, test_idx_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [31:0]        a0_q, a0_d;
  logic               timeout_q, timeout_d;
  logic [CYC_W-1:0]   last_cycles_q, last_cycles_d;
  logic [IDX_W:0]     pass_count_q, pass_count_d;
  logic [IDX_W:0]     err_count_q, err_count_d;
  logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic               first_err_valid_q, first_err_valid_d;
  logic [1:0]         code;

  // Classification uses only registered halt data, so retire_*/a0_value never reach outputs.
  always_comb begin
    if (timeout_q)                code = 2'd3;
    else if (a0_q == PASS_MAGIC)  code = 2'd0;
    else if (a0_q == FAIL_MAGIC)  code = 2'd1;
    else                          code = 2'd2;
  end

  always_comb begin
    state_d           = state_q;
    test_idx_d        = test_idx_q;
    rst_cnt_d         = rst_cnt_q;
    cycle_cnt_d       = cycle_cnt_q;
    a0_d              = a0_q;
    timeout_d         = timeout_q;
    last_cycles_d     = last_cycles_q;
    pass_count_d      = pass_count_q;
    err_count_d       = err_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;

    // Abort freezes everything, including a result in flight, so the scoreboard stays consistent.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d           = S_LOAD;
            test_idx_d        = '0;
            pass_count_d      = '0;
            err_count_d       = '0;
            first_err_idx_d   = '0;
            first_err_valid_d = 1'b0;
            last_cycles_d     = '0;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            state_d   = S_RST;
            rst_cnt_d = '0;
          end
        end
        S_RST: begin
          if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
            state_d     = S_RUN;
            cycle_cnt_d = CYC_W'(1);
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (retire_valid && (retire_instr == HALT_INSTR)) begin
            state_d   = S_CHECK;
            a0_d      = a0_value;
            timeout_d = 1'b0;
          end else if (cycle_cnt_q == CYC_W'(MAX_CYCLES)) begin
            state_d   = S_CHECK;
            timeout_d = 1'b1;
          end else begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          last_cycles_d = cycle_cnt_q;
          if (code == 2'd0) begin
            if (pass_count_q != '1) pass_count_d = pass_count_q + 1'b1;
          end else begin
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (!first_err_valid_q) begin
              first_err_valid_d = 1'b1;
              first_err_idx_d   = test_idx_q;
            end
          end
          if (test_idx_q == IDX_W'(NUM_TESTS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_LOAD;
            test_idx_d = test_idx_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      test_idx_q        <= '0;
      rst_cnt_q         <= '0;
      cycle_cnt_q       <= '0;
      a0_q              <= '0;
      timeout_q         <= 1'b0;
      last_cycles_q     <= '0;
      pass_count_q      <= '0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      test_idx_q        <= test_idx_d;
      rst_cnt_q         <= rst_cnt_d;
      cycle_cnt_q       <= cycle_cnt_d;
      a0_q              <= a0_d;
      timeout_q         <= timeout_d;
      last_cycles_q     <= last_cycles_d;
      pass_count_q      <= pass_count_d;
      err_count_q       <= err_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign load_req        = (state_q == S_LOAD);
  assign cpu_rst_n       = (state_q == S_RUN);
  assign busy            = (state_q == S_LOAD) || (state_q == S_RST) ||
                           (state_q == S_RUN)  || (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign all_pass        = (state_q == S_DONE) && (err_count_q == '0);
  assign result_valid    = (state_q == S_CHECK) && !abort;
  assign result_code     = result_valid ? code : 2'd0;
  assign test_idx        = test_idx_q;
  assign last_cycles     = last_cycles_q;
  assign pass_count      = pass_count_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Directed bench for riscv_test_sequencer: NUM_TESTS=3, MAX_CYCLES=20, RESET_CYCLES=2.
module tb_riscv_test_sequencer;

  localparam logic [31:0] HALT = 32'hdead10cc;
  localparam logic [31:0] PASS = 32'h00c0ffee;
  localparam logic [31:0] FAIL = 32'hdeaddead;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        load_req;
  logic        load_done = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_instr = '0;
  logic [31:0] a0_value = '0;
  logic        cpu_rst_n;
  logic [1:0]  test_idx;
  logic        busy, done, all_pass, result_valid;
  logic [1:0]  result_code;
  logic [31:0] last_cycles;
  logic [2:0]  pass_count, err_count;
  logic [1:0]  first_err_idx;
  logic        first_err_valid;

  int n_vec  = 0;
  int n_miss = 0;

  riscv_test_sequencer #(
    .NUM_TESTS(3), .IDX_W(2), .CYC_W(32), .MAX_CYCLES(20), .RESET_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .load_req(load_req), .load_done(load_done),
    .retire_valid(retire_valid), .retire_instr(retire_instr), .a0_value(a0_value),
    .cpu_rst_n(cpu_rst_n), .test_idx(test_idx), .busy(busy), .done(done),
    .all_pass(all_pass), .result_valid(result_valid), .result_code(result_code),
    .last_cycles(last_cycles), .pass_count(pass_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays one image: loader handshake after ldly cycles, then a CPU that retires nops
  // and the halt instruction on RUN cycle 'halt' (0 = never halts).
  task automatic run_test(input int idx, input int halt, input logic [31:0] a0v,
                          input int ldly, input logic [1:0] exp_code, input int exp_last);
    int n;
    int k;
    n = 0;
    while (!load_req && n < 200) begin tick(); n++; end
    check("load_req", load_req, 1);
    check("test_idx", test_idx, idx);
    for (int d = 0; d < ldly; d++) tick();
    if (ldly > 0) begin
      check("load_req_held", load_req, 1);
      check("cpu_rst_load", cpu_rst_n, 0);
    end
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("load_req_drop", load_req, 0);
    n = 0;
    while (!cpu_rst_n && n < 20) begin tick(); n++; end
    check("rst_low_cycles", n, 2);
    k = 1;
    while (!result_valid && k < 100) begin
      retire_valid = 1'b1;
      retire_instr = (k == halt) ? HALT : 32'h00000013 + k;
      a0_value     = (k == halt || halt == 0) ? a0v : 32'h11111111;
      tick();
      retire_valid = 1'b0;
      retire_instr = '0;
      a0_value     = 32'h22222222;
      k++;
    end
    check("result_valid", result_valid, 1);
    check("result_code", result_code, exp_code);
    check("cpu_rst_check", cpu_rst_n, 0);
    tick();
    check("result_pulse", result_valid, 0);
    check("last_cycles", last_cycles, exp_last);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_load_req", load_req, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_all_pass", all_pass, 0);
    check("rst_result", {result_valid, result_code}, 0);
    check("rst_counts", {pass_count, err_count, test_idx}, 0);
    check("rst_last", last_cycles, 0);
    reset = 1'b1;
    tick();

    // All three pass at RUN cycle 5.
    pulse_start();
    check("busy_after_start", busy, 1);
    run_test(0, 5, PASS, 1, 2'd0, 5);
    check("pass_after_t0", pass_count, 1);
    run_test(1, 5, PASS, 1, 2'd0, 5);
    run_test(2, 5, PASS, 1, 2'd0, 5);
    check("s1_done", done, 1);
    check("s1_all_pass", all_pass, 1);
    check("s1_pass", pass_count, 3);
    check("s1_err", err_count, 0);
    check("s1_fev", first_err_valid, 0);
    check("s1_busy", busy, 0);

    // Codes 0, 1, 2.
    pulse_start();
    check("s2_cleared", {pass_count, err_count}, 0);
    check("s2_done_low", done, 0);
    run_test(0, 3, PASS, 1, 2'd0, 3);
    run_test(1, 7, FAIL, 1, 2'd1, 7);
    run_test(2, 1, 32'h12345678, 1, 2'd2, 1);
    check("s2_pass", pass_count, 1);
    check("s2_err", err_count, 2);
    check("s2_fei", first_err_idx, 1);
    check("s2_fev", first_err_valid, 1);
    check("s2_all_pass", all_pass, 0);
    check("s2_done", done, 1);

    // Timeout, halt on the timeout cycle, slow loader.
    pulse_start();
    run_test(0, 0, PASS, 1, 2'd3, 20);
    run_test(1, 20, PASS, 1, 2'd0, 20);
    run_test(2, 2, FAIL, 50, 2'd1, 2);
    check("s3_pass", pass_count, 1);
    check("s3_err", err_count, 2);
    check("s3_fei", first_err_idx, 0);
    check("s3_done", done, 1);

    // Abort during RUN of test 1.
    pulse_start();
    run_test(0, 4, PASS, 1, 2'd0, 4);
    while (!load_req) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("s4_in_run", cpu_rst_n, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cpu_rst", cpu_rst_n, 0);
    check("abort_load_req", load_req, 0);
    check("abort_rv", result_valid, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass_count, 1);
    check("abort_idx", test_idx, 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", busy, 0);
    check("abort_keeps_pass", pass_count, 1);
    pulse_start();
    check("restart_idx", test_idx, 0);
    check("restart_pass", pass_count, 0);
    check("restart_load_req", load_req, 1);

    // Async reset mid-RUN after one pass; start ignored while busy.
    run_test(0, 2, PASS, 1, 2'd0, 2);
    while (!load_req) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    tick();
    tick();
    check("s5_in_run", cpu_rst_n, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_run", cpu_rst_n, 1);
    check("start_ignored_idx", test_idx, 1);
    check("s5_pass", pass_count, 1);
    #3 reset = 1'b0;
    #1;
    check("async_cpu_rst", cpu_rst_n, 0);
    check("async_busy", busy, 0);
    check("async_counts", {pass_count, test_idx}, 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle", {busy, done, load_req}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
